// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: data width and receiver state encoding.
package uart_defs_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/input_synchroniser.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset level.
module input_synchroniser #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, level-valid handshake, sticky error flag.
module uart_rx
  import uart_defs_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 1000
) (
  input  logic                      i_clock,
  input  logic                      i_resetN,
  input  logic                      i_rxSerial,
  input  logic                      i_rxAck,
  input  logic                      i_errorClear,
  output logic [UART_DATA_BITS-1:0] o_rxData,
  output logic                      o_rxValid,
  output logic                      o_rxBusy,
  output logic                      o_framingError,
  output logic                      o_overrun,
  output logic                      o_rxError
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  generate
    if (CLOCKS_PER_BIT < 4) begin : g_bad_clocks_per_bit
      $error("uart_rx: CLOCKS_PER_BIT must be at least 4");
    end
  endgenerate

  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      rx_s;

  input_synchroniser #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk  (i_clock),
    .rst_n(i_resetN),
    .d    (i_rxSerial),
    .q    (rx_s)
  );

  // IDLE is only ever entered with rx_s high (or from reset with the
  // synchroniser preset high), so rx_s low in IDLE is a falling edge.
  always_ff @(posedge i_clock) begin
    if (!i_resetN) begin
      state          <= RX_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      o_rxData       <= '0;
      o_rxValid      <= 1'b0;
      o_rxBusy       <= 1'b0;
      o_framingError <= 1'b0;
      o_overrun      <= 1'b0;
      o_rxError      <= 1'b0;
    end else begin
      o_framingError <= 1'b0;
      o_overrun      <= 1'b0;
      cnt            <= cnt + 1'b1;
      if (i_rxAck && o_rxValid) o_rxValid <= 1'b0;
      if (i_errorClear)         o_rxError <= 1'b0;

      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state    <= RX_START;
            o_rxBusy <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx_s) begin
              state    <= RX_IDLE;
              o_rxBusy <= 1'b0;
            end else begin
              state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state    <= RX_IDLE;
              o_rxBusy <= 1'b0;
              // Load overrides the same-cycle ack clear above.
              if (!o_rxValid || i_rxAck) begin
                o_rxData  <= shift;
                o_rxValid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
                o_rxError <= 1'b1;
              end
            end else begin
              state          <= RX_WAIT_IDLE;
              o_framingError <= 1'b1;
              o_rxError      <= 1'b1;
            end
          end
        end
        RX_WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state    <= RX_IDLE;
            o_rxBusy <= 1'b0;
          end
        end
        default: begin
          state    <= RX_IDLE;
          o_rxBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
